// File: rtl/c17_bist_pkg.sv
// Shared types, widths, polynomial taps and C17 pin mapping for the C17 BIST controller.
package c17_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int LFSR_W = 5;
  localparam int MISR_W = 8;
  localparam int RESP_W = 2;

  // Tap masks: x^5+x^3+1 and x^8+x^4+x^3+x^2+1.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 5'b10100;
  localparam logic [MISR_W-1:0] MISR_TAPS = 8'b1011_1000;

  localparam int PAT_1GAT   = 0;
  localparam int PAT_2GAT   = 1;
  localparam int PAT_3GAT   = 2;
  localparam int PAT_6GAT   = 3;
  localparam int PAT_7GAT   = 4;
  localparam int RESP_22GAT = 0;
  localparam int RESP_23GAT = 1;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

  function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] s,
                                                  input logic [RESP_W-1:0] r);
    return {s[MISR_W-2:0], ^(s & MISR_TAPS)} ^ {{(MISR_W-2){1'b0}}, r[RESP_23GAT], r[RESP_22GAT]};
  endfunction

  // LFSR bit order maps straight onto the C17 input pins.
  function automatic logic [LFSR_W-1:0] to_pat(input logic [LFSR_W-1:0] l);
    logic [LFSR_W-1:0] p;
    p           = '0;
    p[PAT_1GAT] = l[0];
    p[PAT_2GAT] = l[1];
    p[PAT_3GAT] = l[2];
    p[PAT_6GAT] = l[3];
    p[PAT_7GAT] = l[4];
    return p;
  endfunction

endpackage

// File: rtl/c17_bist_misr.sv
// 8-bit multiple-input signature register with seed load and enable, 2-bit parallel input.
module c17_bist_misr
  import c17_bist_pkg::*;
#(
  parameter logic [MISR_W-1:0] SEED = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [RESP_W-1:0] resp,
  output logic [MISR_W-1:0] sig
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)       sig <= SEED;
    else if (load) sig <= SEED;
    else if (en)   sig <= misr_next(sig, resp);
  end

endmodule

// File: rtl/c17_bist_ctrl.sv
// BIST controller around the C17 netlist: LFSR stimulus, MISR compaction, golden compare.
// Optional macro C17_BIST_RESP_PIPE_EN registers the response ahead of the MISR and adds a DRAIN cycle.
module c17_bist_ctrl
  import c17_bist_pkg::*;
#(
  parameter int unsigned       PATTERN_COUNT = 31,
  parameter logic [LFSR_W-1:0] LFSR_SEED     = 5'b00001,
  parameter logic [MISR_W-1:0] MISR_SEED     = 8'h00,
  parameter logic [MISR_W-1:0] EXP_SIGNATURE = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic [LFSR_W-1:0] pat_o,
  input  logic [RESP_W-1:0] resp_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [MISR_W-1:0] signature_o
);

  localparam int          CNT_W = $clog2(PATTERN_COUNT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PATTERN_COUNT - 1);

  state_t              state, state_nx;
  logic [LFSR_W-1:0]   lfsr;
  logic [CNT_W-1:0]    count;
  logic                start_ok;
  logic                misr_en;
  logic [RESP_W-1:0]   misr_in;

  assign start_ok = start_i && ((state == ST_IDLE) || (state == ST_DONE));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: if (start_i) state_nx = ST_RUN;
      ST_RUN: begin
        if (count == LAST) begin
`ifdef C17_BIST_RESP_PIPE_EN
          state_nx = ST_DRAIN;
`else
          state_nx = ST_DONE;
`endif
        end
      end
      ST_DRAIN: state_nx = ST_DONE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    pat_o  = '0;
    busy_o = 1'b0;
    done_o = 1'b0;
    pass_o = 1'b0;
    case (state)
      ST_RUN: begin
        pat_o  = to_pat(lfsr);
        busy_o = 1'b1;
      end
      ST_DRAIN: busy_o = 1'b1;
      ST_DONE: begin
        done_o = 1'b1;
        pass_o = (signature_o == EXP_SIGNATURE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      lfsr  <= LFSR_SEED;
      count <= '0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        lfsr  <= LFSR_SEED;
        count <= '0;
      end else if (state == ST_RUN) begin
        lfsr  <= lfsr_next(lfsr);
        count <= count + 1'b1;
      end
    end
  end

`ifdef C17_BIST_RESP_PIPE_EN
  logic [RESP_W-1:0] resp_q;

  always_ff @(posedge clk) begin
    if (rst) resp_q <= '0;
    else     resp_q <= resp_i;
  end

  // First RUN cycle has no registered response yet; DRAIN absorbs the last one.
  assign misr_in = resp_q;
  assign misr_en = ((state == ST_RUN) && (count != '0)) || (state == ST_DRAIN);
`else
  assign misr_in = resp_i;
  assign misr_en = (state == ST_RUN);
`endif

  c17_bist_misr #(
    .SEED (MISR_SEED)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (start_ok),
    .en   (misr_en),
    .resp (misr_in),
    .sig  (signature_o)
  );

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Directed bench for c17_bist_ctrl: three instances (PATTERN_COUNT 2, 31, 1) each wired to a behavioural C17.
module tb_c17_bist_ctrl;

`ifdef C17_BIST_RESP_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start2, start31, start1, stuck;
  logic [4:0] pat2, pat31, pat1;
  logic [1:0] resp2, resp31, resp1;
  logic       busy2, done2, pass2, busy31, done31, pass31, busy1, done1, pass1;
  logic [7:0] sig2, sig31, sig1;

  int n_pass = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  // C17: six NAND2 gates; pat[0]=1GAT [1]=2GAT [2]=3GAT [3]=6GAT [4]=7GAT, resp[0]=22GAT [1]=23GAT.
  function automatic logic [1:0] c17(input logic [4:0] p);
    logic n10, n11, n16, n19;
    n10 = ~(p[0] & p[2]);
    n11 = ~(p[2] & p[3]);
    n16 = ~(p[1] & n11);
    n19 = ~(n11 & p[4]);
    return {~(n16 & n19), ~(n10 & n16)};
  endfunction

  function automatic logic [4:0] m_lfsr(input logic [4:0] l);
    return {l[3], l[2], l[1], l[0], l[4] ^ l[2]};
  endfunction

  function automatic logic [7:0] m_misr(input logic [7:0] s, input logic [1:0] r);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb} ^ {6'b000000, r};
  endfunction

  assign resp2  = stuck ? 2'b00 : c17(pat2);
  assign resp31 = c17(pat31);
  assign resp1  = c17(pat1);

  c17_bist_ctrl #(.PATTERN_COUNT(2), .EXP_SIGNATURE(8'h03)) u_p2 (
    .clk(clk), .rst(rst), .start_i(start2), .pat_o(pat2), .resp_i(resp2),
    .busy_o(busy2), .done_o(done2), .pass_o(pass2), .signature_o(sig2));

  c17_bist_ctrl #(.PATTERN_COUNT(31)) u_p31 (
    .clk(clk), .rst(rst), .start_i(start31), .pat_o(pat31), .resp_i(resp31),
    .busy_o(busy31), .done_o(done31), .pass_o(pass31), .signature_o(sig31));

  c17_bist_ctrl #(.PATTERN_COUNT(1), .LFSR_SEED(5'b00010), .EXP_SIGNATURE(8'h03)) u_p1 (
    .clk(clk), .rst(rst), .start_i(start1), .pat_o(pat1), .resp_i(resp1),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1), .signature_o(sig1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Start the PATTERN_COUNT=2 instance and walk it to DONE, checking every cycle.
  task automatic run_p2(input string tag, input logic [1:0] r1, input logic [7:0] exp_sig,
                        input logic exp_pass);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check({tag, "_c1_pat"},  32'(pat2),  32'h01);
    check({tag, "_c1_busy"}, 32'(busy2), 32'h1);
    check({tag, "_c1_done"}, 32'(done2), 32'h0);
    check({tag, "_c1_pass"}, 32'(pass2), 32'h0);
    tick();
    check({tag, "_c2_pat"},  32'(pat2),  32'h02);
    check({tag, "_c2_resp"}, 32'(resp2), 32'(r1));
    tick();
    if (PIPE != 0) begin
      check({tag, "_drain_busy"}, 32'(busy2), 32'h1);
      check({tag, "_drain_pat"},  32'(pat2),  32'h0);
      check({tag, "_drain_done"}, 32'(done2), 32'h0);
      tick();
    end
    check({tag, "_done"}, 32'(done2), 32'h1);
    check({tag, "_busy"}, 32'(busy2), 32'h0);
    check({tag, "_pat0"}, 32'(pat2),  32'h0);
    check({tag, "_sig"},  32'(sig2),  32'(exp_sig));
    check({tag, "_pass"}, 32'(pass2), 32'(exp_pass));
  endtask

  initial begin : stim
    logic [31:0] seen;
    logic [4:0]  ml;
    logic [7:0]  ms;
    int          bc, dup, pat_err;

    rst = 1'b1; start2 = 1'b0; start31 = 1'b0; start1 = 1'b0; stuck = 1'b0;
    tick();
    tick();
    check("rst_pat",  32'(pat2),  32'h0);
    check("rst_busy", 32'(busy2), 32'h0);
    check("rst_done", 32'(done2), 32'h0);
    check("rst_pass", 32'(pass2), 32'h0);
    check("rst_sig",  32'(sig2),  32'h0);
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy31), 32'h0);

    // Two patterns with a real C17: responses 00 then 11 give signature 03.
    run_p2("p2", 2'b11, 8'h03, 1'b1);
    tick();
    tick();
    check("p2_hold_done", 32'(done2), 32'h1);
    check("p2_hold_sig",  32'(sig2),  32'h03);

    // Restart from DONE reproduces the signature; done drops during the rerun.
    run_p2("p2_rerun", 2'b11, 8'h03, 1'b1);

    // Stuck-at-00 response compacts to 00 and misses the golden value.
    stuck = 1'b1;
    run_p2("p2_stuck", 2'b00, 8'h00, 1'b0);
    stuck = 1'b0;

    // Full-period run against the reference model.
    seen = '0; dup = 0; pat_err = 0; bc = 0; ml = 5'b00001; ms = 8'h00;
    start31 = 1'b1;
    tick();
    start31 = 1'b0;
    for (int i = 0; i < 60 && !done31; i++) begin
      if (busy31) begin
        bc++;
        if (pat31 != 5'b0) begin
          if (seen[pat31]) dup++;
          seen[pat31] = 1'b1;
          if (pat31 !== ml) pat_err++;
          ms = m_misr(ms, c17(ml));
          ml = m_lfsr(ml);
        end
      end
      tick();
    end
    check("p31_done",    32'(done31), 32'h1);
    check("p31_busy_n",  32'(bc),     32'(31 + PIPE));
    check("p31_seen",    seen,        32'hFFFF_FFFE);
    check("p31_dup",     32'(dup),    32'h0);
    check("p31_seq",     32'(pat_err), 32'h0);
    check("p31_sig",     32'(sig31),  32'(ms));
    check("p31_pass",    32'(pass31), 32'(ms == 8'h00));

    // start_i mid-RUN is ignored: same length, same signature.
    bc = 0;
    start31 = 1'b1;
    tick();
    start31 = 1'b0;
    for (int i = 0; i < 60 && !done31; i++) begin
      start31 = (i == 5);
      if (busy31) bc++;
      tick();
    end
    start31 = 1'b0;
    check("p31_mid_done",   32'(done31), 32'h1);
    check("p31_mid_busy_n", 32'(bc),     32'(31 + PIPE));
    check("p31_mid_sig",    32'(sig31),  32'(ms));

    // Reset mid-RUN returns to IDLE with reset values.
    start31 = 1'b1;
    tick();
    start31 = 1'b0;
    tick();
    tick();
    tick();
    check("p31_pre_rst_busy", 32'(busy31), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_pat",  32'(pat31),  32'h0);
    check("mrst_busy", 32'(busy31), 32'h0);
    check("mrst_done", 32'(done31), 32'h0);
    check("mrst_pass", 32'(pass31), 32'h0);
    check("mrst_sig",  32'(sig31),  32'h0);
    tick();
    check("mrst_idle", 32'(busy31), 32'h0);

    // PATTERN_COUNT=1: exactly one RUN cycle; seed 00010 yields response 11.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("p1_pat",  32'(pat1),  32'h02);
    check("p1_busy", 32'(busy1), 32'h1);
    tick();
    if (PIPE != 0) begin
      check("p1_drain", 32'(busy1), 32'h1);
      tick();
    end
    check("p1_done", 32'(done1), 32'h1);
    check("p1_busy_off", 32'(busy1), 32'h0);
    check("p1_sig",  32'(sig1),  32'h03);
    check("p1_pass", 32'(pass1), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/c17_bist_ctrl.md
Name: c17_bist_ctrl

Overview:
Built-in self-test controller for the C17 benchmark netlist, sitting at the other end of its interface.
- Drives the five C17 primary inputs from a 5-bit LFSR.
- Compacts the two C17 primary outputs into an 8-bit MISR signature.
- Compares the signature against a golden value and reports pass/fail.
- Used in fault-injection and reliability runs as the stimulus source and response sink around the mapped C17.

Parameters:
PATTERN_COUNT, 31, number of patterns applied per run; legal range 1..255.
LFSR_SEED, 5'b00001, LFSR load value at start; must be nonzero.
MISR_SEED, 8'h00, MISR load value at start.
EXP_SIGNATURE, 8'h00, golden signature compared at end of run.

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
start_i  in  1  one-cycle start request; sampled only in IDLE or DONE
pat_o  out  5  to C17: [0]=1GAT [1]=2GAT [2]=3GAT [3]=6GAT [4]=7GAT
resp_i  in  2  from C17: [0]=22GAT [1]=23GAT (combinational response to pat_o)
busy_o  out  1  high in RUN (and DRAIN)
done_o  out  1  high in DONE, level
pass_o  out  1  (signature_o == EXP_SIGNATURE); valid only while done_o=1, else 0
signature_o  out  8  current MISR contents

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst; it wins over all other inputs, including mid-run.
- Reset values: state=IDLE; lfsr=LFSR_SEED; misr=MISR_SEED; count=0; pat_o=0; busy_o=0; done_o=0; pass_o=0; signature_o=MISR_SEED.
- FSM states: IDLE, RUN, DRAIN (DRAIN exists only with the optional feature), DONE.
- IDLE or DONE with start_i=1: load lfsr=LFSR_SEED, misr=MISR_SEED, count=0, go to RUN.
  - start_i in RUN or DRAIN is ignored.
  - DONE holds, with signature stable, until start_i or rst.
- pat_o: equals lfsr while in RUN, else 5'b0.
- Each RUN cycle:
  - MISR absorbs resp_i for the current pat_o.
  - lfsr advances.
  - count increments.
  - When count reaches PATTERN_COUNT-1 in that cycle, the next state is DONE, or DRAIN with the optional feature.
- LFSR: Fibonacci, x^5+x^3+1. next = {lfsr[3:0], lfsr[4]^lfsr[2]}. Period 31; patterns repeat when PATTERN_COUNT > 31.
- MISR: x^8+x^4+x^3+x^2+1. fb = misr[7]^misr[5]^misr[4]^misr[3]; next = {misr[6:0], fb} ^ {6'b0, resp}.
- Latency: start_i accepted at edge 0 → RUN for edges 1..PATTERN_COUNT → done_o=1 from cycle PATTERN_COUNT+1.
- count width: $clog2(PATTERN_COUNT+1).
- PATTERN_COUNT=1: exactly one RUN cycle.

Optional Feature:
C17_BIST_RESP_PIPE_EN
- Defined:
  - resp_i is registered (resp_q, reset 0) before the MISR; the MISR absorbs resp_q.
  - The first RUN cycle does not update the MISR.
  - After the last RUN cycle the FSM enters DRAIN for one cycle: busy_o=1, pat_o=0, MISR absorbs the final resp_q.
  - done_o asserts one cycle later than without the feature.
  - Final signature is identical to the undefined case.
- Undefined: direct combinational capture as above; no DRAIN state.

Decomposition:
- Package c17_bist_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - LFSR/MISR widths (5, 8)
  - tap constants
  - pattern and response bit-index constants
- One natural sub-module: c17_bist_misr (8-bit MISR with load/enable, 2-bit parallel input). LFSR, counter and FSM stay in the top module.

Test Plan:
1. Reset: rst=1 for 2 cycles → pat_o=0, busy_o=0, done_o=0, pass_o=0, signature_o=8'h00.
2. PATTERN_COUNT=2, EXP_SIGNATURE=8'h03, real C17 attached, start_i pulse:
   - pat_o=5'b00001 then 5'b00010
   - resp_i=2'b00 then 2'b11
   - done_o=1 at cycle 3 (cycle 4 with C17_BIST_RESP_PIPE_EN), signature_o=8'h03, pass_o=1
3. Same as 2 with resp_i forced to 2'b00 (stuck fault) → signature_o=8'h00, pass_o=0.
4. PATTERN_COUNT=31, bench reference model: pat_o visits all 31 nonzero values exactly once; signature_o matches the model; busy_o high for exactly 31 cycles.
5. start_i pulsed mid-RUN → ignored, run length unchanged. rst asserted mid-RUN → next cycle IDLE with all reset values.
6. In DONE, new start_i → lfsr and MISR reloaded with seeds, identical signature reproduced, done_o deasserted during the rerun.
